// File: rtl/control_carrera.sv
// rtl/control_carrera.sv - race-control front end: input conditioning and race sequencing FSM
module control_carrera #(
  parameter int CLK_FREQ          = 25_000_000,
  parameter int DEBOUNCE_MS       = 10,
  parameter int MIN_RUN_MS        = 1000,
  parameter bit SENSOR_ACTIVE_LOW = 1'b1
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       btn_start,
  input  logic       btn_reset,
  input  logic       sensor_salida,
  input  logic       sensor_meta,
  output logic       reset_timer,
  output logic       enable_timer,
  output logic [1:0] estado,
  output logic       led_listo,
  output logic       led_corriendo,
  output logic       led_fin
);

  localparam int DEB_CYCLES     = CLK_FREQ / 1000 * DEBOUNCE_MS;
  localparam int MIN_RUN_CYCLES = CLK_FREQ / 1000 * MIN_RUN_MS;
  localparam int DEB_W          = (DEB_CYCLES > 1) ? $clog2(DEB_CYCLES) : 1;
  // +1 so the saturation value itself is representable even for power-of-two windows
  localparam int RUN_W          = $clog2(MIN_RUN_CYCLES + 1);
  localparam int NCH            = 4;
  localparam int CH_START       = 0;
  localparam int CH_RESET       = 1;
  localparam int CH_SALIDA      = 2;
  localparam int CH_META        = 3;
  localparam logic POL          = SENSOR_ACTIVE_LOW;

  typedef enum logic [1:0] {
    IDLE     = 2'b00,
    ARMED    = 2'b01,
    RUNNING  = 2'b10,
    FINISHED = 2'b11
  } state_t;

  state_t               state_q, state_d;
  logic [RUN_W-1:0]     run_q, run_d;
  logic [NCH-1:0]       raw_norm;
  logic [NCH-1:0]       sync1_q, sync2_q;
  logic [NCH-1:0]       deb_q, deb_d;
  logic [NCH-1:0]       deb_prev_q;
  logic [DEB_W-1:0]     cnt_q [NCH];
  logic [DEB_W-1:0]     cnt_d [NCH];
  logic [NCH-1:0]       pulse;
  logic                 blank_done;

  // Sensors are normalised so that 1 always means "line crossed"; buttons are already active-high
  assign raw_norm = {sensor_meta ^ POL, sensor_salida ^ POL, btn_reset, btn_start};

  // Debounce: count consecutive cycles of disagreement, adopt the synced value after DEB_CYCLES of them
  always_comb begin
    deb_d = deb_q;
    for (int i = 0; i < NCH; i++) begin
      cnt_d[i] = '0;
      if (sync2_q[i] != deb_q[i]) begin
        if (cnt_q[i] == DEB_W'(DEB_CYCLES - 1)) begin
          deb_d[i] = sync2_q[i];
        end else begin
          cnt_d[i] = cnt_q[i] + DEB_W'(1);
        end
      end
    end
  end

  // Synchroniser, debounce and edge-history registers for all four channels
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync1_q    <= '0;
      sync2_q    <= '0;
      deb_q      <= '0;
      deb_prev_q <= '0;
      for (int i = 0; i < NCH; i++) cnt_q[i] <= '0;
    end else begin
      sync1_q    <= raw_norm;
      sync2_q    <= sync1_q;
      deb_q      <= deb_d;
      deb_prev_q <= deb_q;
      for (int i = 0; i < NCH; i++) cnt_q[i] <= cnt_d[i];
    end
  end

  assign pulse      = deb_q & ~deb_prev_q;
  assign blank_done = (run_q == RUN_W'(MIN_RUN_CYCLES));

  // Race sequencing; the reset button wins over any other pulse arriving in the same cycle
  always_comb begin
    state_d = state_q;
    if (pulse[CH_RESET]) begin
      state_d = IDLE;
    end else begin
      case (state_q)
        IDLE:     if (pulse[CH_START])  state_d = ARMED;
        ARMED:    if (pulse[CH_SALIDA]) state_d = RUNNING;
        RUNNING:  if (pulse[CH_META] && blank_done) state_d = FINISHED;
        FINISHED: state_d = FINISHED;
        default:  state_d = IDLE;
      endcase
    end
  end

  // Blanking counter: zero outside RUNNING, so it restarts on every entry, then saturates
  always_comb begin
    run_d = '0;
    if (state_q == RUNNING) begin
      run_d = blank_done ? run_q : run_q + RUN_W'(1);
    end
  end

  // State and blanking counter registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      run_q   <= '0;
    end else begin
      state_q <= state_d;
      run_q   <= run_d;
    end
  end

  assign estado        = state_q;
  assign reset_timer   = (state_q == IDLE) || (state_q == ARMED);
  assign enable_timer  = (state_q == RUNNING);
  assign led_listo     = (state_q == ARMED);
  assign led_corriendo = (state_q == RUNNING);
  assign led_fin       = (state_q == FINISHED);

endmodule
